// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh drain arbiter.
package mesh_arb_pkg;

  // Output register occupancy: EMPTY has no word, HELD presents one word.
  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  // Terminal count of a rows x columns mesh: one terminal per edge port.
  function automatic int nterm(input int rows, input int columns);
    return rows * 2 + columns * 2;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. The search starts one past last_grant_i
// and wraps; the request vector is doubled so a single right shift rotates
// the start position down to bit 0, then a priority encoder finds the first
// requester and the offset is mapped back to an absolute terminal index.
module rr_pick #(
  parameter int NTERM = 16,
  parameter int PW    = $clog2(NTERM)
) (
  input  logic [NTERM-1:0] req_i,
  input  logic [PW-1:0]    last_grant_i,
  output logic             any_o,
  output logic [PW-1:0]    winner_o
);

  logic [2*NTERM-1:0] req2;
  logic [NTERM-1:0]   rot;
  int                 start;
  int                 offset;
  int                 abs_idx;
  logic               found;

  // Rotate the requests so the search start lands at bit 0, then encode.
  always_comb begin
    req2     = {req_i, req_i};
    start    = (int'(last_grant_i) >= NTERM - 1) ? 0 : int'(last_grant_i) + 1;
    rot      = NTERM'(req2 >> start);
    offset   = 0;
    found    = 1'b0;
    for (int j = 0; j < NTERM; j++) begin
      if (rot[j] && !found) begin
        offset = j;
        found  = 1'b1;
      end
    end
    abs_idx  = start + offset;
    if (abs_idx >= NTERM) begin
      abs_idx = abs_idx - NTERM;
    end
    any_o    = |req_i;
    winner_o = PW'(abs_idx);
  end

endmodule

// File: rtl/mesh_drain_arbiter.sv
// Drains the mesh router's terminal outputs into one collector stream.
// Output handshake: a word is transferred on every rising edge where
// out_valid and out_ready are both high; while out_valid is high and
// out_ready is low, out_data/out_port are held stable and no new word is
// popped. out_valid never drops without a transfer except through reset.
module mesh_drain_arbiter
  import mesh_arb_pkg::*;
#(
  parameter  int rows    = 4,
  parameter  int columns = 4,
  parameter  int pckg_sz = 40,
  localparam int NTERM   = nterm(rows, columns),
  localparam int PW      = $clog2(NTERM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NTERM-1:0]   pndng,
  input  logic [pckg_sz-1:0] data_out [NTERM],
  output logic [NTERM-1:0]   pop,
  output logic               out_valid,
  output logic [pckg_sz-1:0] out_data,
  output logic [PW-1:0]      out_port,
  input  logic               out_ready,
  output logic [31:0]        drain_cnt
);

  state_e             state_q;
  logic [pckg_sz-1:0] out_data_q;
  logic [PW-1:0]      out_port_q;
  logic [PW-1:0]      last_grant_q;
  logic [NTERM-1:0]   mask_q;
  logic [31:0]        drain_cnt_q;
  logic [31:0]        drain_cnt_d;

  logic [NTERM-1:0]   eligible;
  logic               pick_any;
  logic [PW-1:0]      pick_winner;
  logic               load;
  logic               deliver;

  // A terminal popped last cycle may still show pndng for one more cycle,
  // so it sits out exactly one arbitration round.
  assign eligible = pndng & ~mask_q;

  rr_pick #(
    .NTERM(NTERM),
    .PW   (PW)
  ) u_pick (
    .req_i       (eligible),
    .last_grant_i(last_grant_q),
    .any_o       (pick_any),
    .winner_o    (pick_winner)
  );

  // Take a new word when enabled, something is eligible and the output
  // register is free or being emptied this cycle. Reset blocks it at once.
  always_comb begin
    load = ~reset & en & pick_any & ((state_q == EMPTY) | out_ready);
  end

  // One-hot consume strobe to the winning terminal.
  always_comb begin
    pop = '0;
    if (load) begin
      pop[pick_winner] = 1'b1;
    end
  end

  assign deliver = (state_q == HELD) & out_ready;

  // Delivered-word counter next value; wraps naturally at 2^32.
  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if (deliver) begin
      drain_cnt_d = drain_cnt_q + 32'd1;
    end
  end

  // Output-register FSM with grant pointer and one-cycle pop mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_port_q   <= '0;
      last_grant_q <= PW'(NTERM - 1);
      mask_q       <= '0;
    end else begin
      mask_q <= pop;
      case (state_q)
        EMPTY: begin
          if (load) begin
            out_data_q   <= data_out[pick_winner];
            out_port_q   <= pick_winner;
            last_grant_q <= pick_winner;
            state_q      <= HELD;
          end
        end
        HELD: begin
          if (load) begin
            out_data_q   <= data_out[pick_winner];
            out_port_q   <= pick_winner;
            last_grant_q <= pick_winner;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Count every completed output transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt_q <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign out_valid = (state_q == HELD);
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign drain_cnt = drain_cnt_q;

endmodule
